// File: rtl/nios_system_rst_ctrl_pkg.sv
// Shared types and constants for the Nios II reset-button controller:
// FSM encoding, Avalon register map and register bit positions.
package nios_system_rst_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_PULSE    = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int EDGE_PRESS   = 0;
    localparam int EDGE_RELEASE = 1;
    localparam int EDGE_LONG    = 2;

    localparam int CTRL_LP_EN   = 0;
    localparam int CTRL_SW_RST  = 1;
    localparam int CTRL_RST_REQ = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nios_system_debounce.sv
// Two-flop synchronizer, polarity normalization and debounce filter for
// the reset pushbutton. rise/fall strobe in the cycle before stable flips.
module nios_system_debounce
    import nios_system_rst_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_port,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int             CW             = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST       = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic           RELEASED_LEVEL = ACTIVE_LOW;

    logic          sync1;
    logic          sync2;
    logic          pressed_sync;
    logic [CW-1:0] cnt;
    logic          settle;

    // Synchronizer flops come out of reset at the released pin level so
    // no spurious press is seen while reset is being released.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= RELEASED_LEVEL;
            sync2 <= RELEASED_LEVEL;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    assign pressed_sync = ACTIVE_LOW ? ~sync2 : sync2;
    assign settle       = (pressed_sync != stable) && (cnt == CNT_LAST);
    assign rise         = settle & pressed_sync;
    assign fall         = settle & ~pressed_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (pressed_sync == stable) begin
            cnt <= '0;
        end else if (settle) begin
            stable <= pressed_sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nios_system_rst_ctrl.sv
// Avalon-MM reset-button controller: event/mask/control registers, level
// interrupt, and the long-press / software reset request sequencer.
module nios_system_rst_ctrl
    import nios_system_rst_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter int unsigned LONG_PRESS_CYCLES = 150000000,
    parameter int unsigned PULSE_CYCLES      = 16,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        in_port,
    output logic        irq,
    output logic        rst_req
);

    localparam int            HW        = cnt_width(LONG_PRESS_CYCLES);
    localparam int            PW        = cnt_width(PULSE_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

    logic          stable;
    logic          rise;
    logic          fall;

    logic          wr;
    logic          sw_rst;
    logic [2:0]    edge_clr;
    logic [2:0]    edge_set;
    logic [2:0]    edge_q;
    logic [2:0]    mask_q;
    logic          lp_en;
    logic [31:0]   rd_mux;
    logic          unused_wdata;

    state_t        state;
    state_t        state_next;
    logic [HW-1:0] hold_cnt;
    logic [PW-1:0] pulse_cnt;
    logic          hold_done;
    logic          pulse_done;
    logic          long_fire;

    nios_system_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .stable  (stable),
        .rise    (rise),
        .fall    (fall)
    );

    assign wr           = chipselect & ~write_n;
    assign sw_rst       = wr && (address == ADDR_CTRL) && writedata[CTRL_SW_RST];
    assign edge_clr     = (wr && (address == ADDR_EDGE)) ? writedata[2:0] : 3'b000;
    assign edge_set     = {long_fire, fall, rise};
    assign unused_wdata = ^writedata[31:3];

    assign hold_done  = (hold_cnt == HOLD_LAST);
    assign pulse_done = (pulse_cnt == PULSE_LAST);

    // Software reset takes priority over button activity in IDLE/HOLD.
    always_comb begin
        state_next = state;
        long_fire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sw_rst)      state_next = ST_PULSE;
                else if (stable) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (sw_rst) begin
                    state_next = ST_PULSE;
                end else if (!stable) begin
                    state_next = ST_IDLE;
                end else if (hold_done && lp_en) begin
                    long_fire  = 1'b1;
                    state_next = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (pulse_done) state_next = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!stable) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            pulse_cnt <= '0;
            rst_req   <= 1'b0;
        end else begin
            state   <= state_next;
            rst_req <= (state == ST_PULSE);
            // Hold count saturates so a disabled long press never wraps.
            if (state != ST_HOLD)  hold_cnt <= '0;
            else if (!hold_done)   hold_cnt <= hold_cnt + 1'b1;
            if (state != ST_PULSE) pulse_cnt <= '0;
            else                   pulse_cnt <= pulse_cnt + 1'b1;
        end
    end

    // Event set is OR-ed after the clear so a simultaneous event wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_q <= 3'b000;
            mask_q <= 3'b000;
            lp_en  <= 1'b1;
            irq    <= 1'b0;
        end else begin
            edge_q <= (edge_q & ~edge_clr) | edge_set;
            irq    <= |(edge_q & mask_q);
            if (wr && (address == ADDR_MASK)) mask_q <= writedata[2:0];
            if (wr && (address == ADDR_CTRL)) lp_en  <= writedata[CTRL_LP_EN];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[0]   = stable;
            ADDR_EDGE: rd_mux[2:0] = edge_q;
            ADDR_MASK: rd_mux[2:0] = mask_q;
            ADDR_CTRL: begin
                rd_mux[CTRL_LP_EN]   = lp_en;
                rd_mux[CTRL_RST_REQ] = rst_req;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) readdata <= '0;
        else       readdata <= rd_mux;
    end

endmodule

// File: tb/tb_nios_system_rst_ctrl.sv
// Directed bench for the reset-button controller: register vector table
// plus hand-timed debounce, interrupt, long-press and reset sequences.
module tb_nios_system_rst_ctrl;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_EDGE = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        in_port;
    logic        irq;
    logic        rst_req;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        do_write;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[10];

    nios_system_rst_ctrl #(
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (20),
        .PULSE_CYCLES      (3),
        .ACTIVE_LOW        (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq),
        .rst_req    (rst_req)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        address = addr;
        tick();
        data = readdata;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Counts rst_req high cycles and rising edges over n ticks.
    task automatic watch_rst(input int n, output int highs, output int rises, output int first);
        logic prev;
        highs = 0;
        rises = 0;
        first = -1;
        prev  = rst_req;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (rst_req) begin
                highs++;
                if (first < 0) first = i;
            end
            if (rst_req && !prev) rises++;
            prev = rst_req;
        end
    endtask

    task automatic run_vectors(input int lo, input int hi);
        logic [31:0] rd;
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].do_write) bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, rd);
            check($sformatf("vec%0d_read", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          k;
        int          highs;
        int          rises;
        int          first;
        logic        got;

        vecs[0] = '{1'b0, A_DATA, 32'h0,        32'h0, 1'b0};
        vecs[1] = '{1'b0, A_EDGE, 32'h0,        32'h0, 1'b0};
        vecs[2] = '{1'b0, A_MASK, 32'h0,        32'h0, 1'b0};
        vecs[3] = '{1'b0, A_CTRL, 32'h0,        32'h1, 1'b0};
        vecs[4] = '{1'b1, A_DATA, 32'hFFFFFFFF, 32'h0, 1'b0};
        vecs[5] = '{1'b1, A_MASK, 32'hFFFFFFFF, 32'h7, 1'b0};
        vecs[6] = '{1'b1, A_MASK, 32'h00000005, 32'h5, 1'b0};
        vecs[7] = '{1'b1, A_CTRL, 32'hFFFFFFF9, 32'h1, 1'b0};
        vecs[8] = '{1'b1, A_EDGE, 32'h00000007, 32'h0, 1'b0};
        vecs[9] = '{1'b1, A_MASK, 32'h00000000, 32'h0, 1'b0};

        reset      = 1'b1;
        address    = A_DATA;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 1'b1;
        wait_ticks(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        check("reset_rst_req", {31'd0, rst_req}, 32'h0);
        reset = 1'b0;
        tick();

        run_vectors(0, 9);

        // Short glitch must be rejected entirely.
        in_port = 1'b0;
        wait_ticks(2);
        in_port = 1'b1;
        wait_ticks(10);
        bus_read(A_DATA, rd);
        check("glitch_data", rd, 32'h0);
        bus_read(A_EDGE, rd);
        check("glitch_edge", rd, 32'h0);

        // Clean press: stable after 6 clocks, visible in readdata one later.
        address = A_DATA;
        in_port = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i >= 8) address = A_EDGE;
            tick();
            if (i == 6) check("press_data_before", readdata, 32'h0);
            if (i == 7) check("press_data_after", readdata, 32'h1);
            if (i == 9) check("press_edge", readdata, 32'h1);
        end
        in_port = 1'b1;
        wait_ticks(10);
        bus_read(A_EDGE, rd);
        check("release_edge", rd, 32'h3);
        bus_write(A_EDGE, 32'h3);
        bus_read(A_EDGE, rd);
        check("edge_w1c", rd, 32'h0);

        // Interrupt on press, cleared by W1C.
        bus_write(A_MASK, 32'h1);
        in_port = 1'b0;
        k   = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            tick();
            k++;
            if (irq) got = 1'b1;
        end
        check("irq_latency", k, 7);
        bus_write(A_EDGE, 32'h1);
        tick();
        check("irq_cleared", {31'd0, irq}, 32'h0);
        in_port = 1'b1;
        wait_ticks(10);
        check("irq_release_masked", {31'd0, irq}, 32'h0);
        bus_write(A_EDGE, 32'h7);

        // W1C landing on the very edge that sets the press bit.
        in_port = 1'b0;
        wait_ticks(5);
        bus_write(A_EDGE, 32'h1);
        bus_read(A_EDGE, rd);
        check("w1c_set_wins", rd, 32'h1);
        in_port = 1'b1;
        wait_ticks(10);
        bus_write(A_EDGE, 32'h7);
        bus_write(A_MASK, 32'h0);

        // Long press with lp_en=1.
        in_port = 1'b0;
        watch_rst(30, highs, rises, first);
        check("lp_first_rst_req", first, 28);
        check("lp_pulse_width", highs, 3);
        in_port = 1'b1;
        watch_rst(20, highs, rises, first);
        check("lp_no_second_pulse", highs, 0);
        bus_read(A_EDGE, rd);
        check("lp_edge", rd, 32'h7);
        bus_write(A_EDGE, 32'h7);

        // Software reset from IDLE proves the FSM came back.
        bus_write(A_CTRL, 32'h3);
        watch_rst(8, highs, rises, first);
        check("sw_first", first, 1);
        check("sw_width", highs, 3);
        check("sw_rises", rises, 1);
        bus_read(A_CTRL, rd);
        check("ctrl_sw_reads0", rd, 32'h1);

        // lp_en=0: holding produces nothing until software asks.
        bus_write(A_CTRL, 32'h0);
        in_port = 1'b0;
        watch_rst(40, highs, rises, first);
        check("nolp_no_pulse", highs, 0);
        bus_write(A_CTRL, 32'h2);
        watch_rst(8, highs, rises, first);
        check("nolp_sw_width", highs, 3);
        check("nolp_sw_first", first, 1);
        in_port = 1'b1;
        wait_ticks(12);
        bus_read(A_EDGE, rd);
        check("nolp_edge", rd, 32'h3);
        bus_read(A_CTRL, rd);
        check("nolp_ctrl", rd, 32'h0);

        // Reset during the second rst_req cycle.
        bus_write(A_MASK, 32'h5);
        tick();
        check("pre_reset_irq", {31'd0, irq}, 32'h1);
        bus_write(A_CTRL, 32'h2);
        tick();
        check("pulse_cycle1", {31'd0, rst_req}, 32'h1);
        tick();
        check("pulse_cycle2", {31'd0, rst_req}, 32'h1);
        reset = 1'b1;
        tick();
        check("abort_rst_req", {31'd0, rst_req}, 32'h0);
        check("abort_irq", {31'd0, irq}, 32'h0);
        check("abort_readdata", readdata, 32'h0);
        reset = 1'b0;
        watch_rst(6, highs, rises, first);
        check("abort_no_resume", highs, 0);
        run_vectors(0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
